fullxor_sched: RTL and testbench

Round-robin scheduler that shares one 5-share full-XOR compression unit (xu) between NREQ requesters.
- Per operation: grants one requester and captures its masked shares.
- Collects fresh randomness words from the random source, issues one compression to xu, and returns the unmasked word tagged with the requester id.
- Sits between the B2A share-conversion clients and the single xu instance.
- Guarantees randomness is never reused and masked shares are not retained after issue.

---
 rtl/fullxor_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/fullxor_sched.sv | 151 +++++++++++++++
 tb/tb_fullxor_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fullxor_sched_pkg.sv
// Shared types and elaboration-time helpers for the full-XOR scheduler.
// Holds the FSM state encoding and the randomness-count formula for xu.
package fullxor_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Random words the compression unit consumes for n shares.
    function automatic int rand_num(input int n);
        int log_k;
        log_k = $clog2(n + 1) - 1;
        return log_k * (2 ** (log_k - 1)) + n - (2 ** log_k);
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Zero latency; the caller decides when the grant is actually taken.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Outer loop walks distance from ptr, so the nearest requester wins.
        for (int i = 0; i < NREQ; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (!found && req[b] && (b == ((int'(ptr) + i) % NREQ))) begin
                    found    = 1'b1;
                    grant[b] = 1'b1;
                    idx      = ID_W'(b);
                end
            end
        end
    end

endmodule

// File: rtl/fullxor_sched.sv
// Shares one full-XOR compression unit among NREQ requesters, round robin, one op at a time.
// RANDNUM+4 cycles per op unstalled; stalls on missing randomness and holds the response until rsp_ready.
module fullxor_sched
    import fullxor_sched_pkg::*;
#(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 5,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int RANDNUM   = rand_num(N_SHARES),
    parameter int NREQ      = 4,
    parameter int ID_W      = id_w(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*MASKWIDTH-1:0] req_x,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    input  logic [K_WIDTH-1:0]        rnd_word,
    output logic                      xu_dvld,
    output logic                      xu_ena,
    output logic [K_WIDTH*RANDNUM-1:0] xu_rnd,
    output logic [MASKWIDTH-1:0]      xu_x,
    input  logic [K_WIDTH-1:0]        xu_z,
    input  logic                      xu_ovld,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [K_WIDTH-1:0]        rsp_z,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam int CNT_W = (RANDNUM > 1) ? $clog2(RANDNUM) : 1;

    state_t                            state;
    state_t                            state_nxt;
    logic [ID_W-1:0]                   ptr;
    logic [ID_W-1:0]                   id;
    logic [CNT_W-1:0]                  cnt;
    logic [MASKWIDTH-1:0]              share_buf;
    logic [RANDNUM-1:0][K_WIDTH-1:0]   rnd_buf;
    logic [K_WIDTH-1:0]                z_q;
    logic [NREQ-1:0][MASKWIDTH-1:0]    req_arr;
    logic [NREQ-1:0]                   gnt;
    logic [ID_W-1:0]                   gnt_idx;
    logic                              gnt_found;
    logic                              last_rnd;

    assign req_arr  = req_x;
    assign last_rnd = (cnt == CNT_W'(RANDNUM - 1));
    assign rsp_z    = z_q;
    assign busy     = (state != S_IDLE);

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rnd_ready = 1'b0;
        xu_dvld   = 1'b0;
        xu_ena    = 1'b0;
        xu_x      = '0;
        xu_rnd    = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        case (state)
            S_IDLE: begin
                if (gnt_found && !rst) begin
                    req_ready = gnt;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                rnd_ready = 1'b1;
                if (rnd_valid && last_rnd) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                xu_dvld   = 1'b1;
                xu_ena    = 1'b1;
                xu_x      = share_buf;
                xu_rnd    = rnd_buf;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                xu_ena = 1'b1;
                if (xu_ovld) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            share_buf <= '0;
            rnd_buf   <= '0;
            z_q       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        share_buf <= req_arr[gnt_idx];
                        id        <= gnt_idx;
                        cnt       <= '0;
                    end
                end
                S_FETCH: begin
                    if (rnd_valid) begin
                        rnd_buf[cnt] <= rnd_word;
                        cnt          <= cnt + 1'b1;
                    end
                end
                // Masked shares and randomness must not outlive the issue cycle.
                S_ISSUE: begin
                    share_buf <= '0;
                    rnd_buf   <= '0;
                end
                S_WAIT: begin
                    if (xu_ovld) z_q <= xu_z;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        ptr <= (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
                        z_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fullxor_sched.sv
// Scoreboard bench for fullxor_sched with a 1-cycle behavioural xu that XORs the five share words.
module tb_fullxor_sched;

    localparam int K    = 32;
    localparam int MW   = 160;
    localparam int RN   = 5;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*MW-1:0] req_x;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [K-1:0]       rnd_word;
    logic               xu_dvld;
    logic               xu_ena;
    logic [K*RN-1:0]    xu_rnd;
    logic [MW-1:0]      xu_x;
    logic [K-1:0]       xu_z;
    logic               xu_ovld;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [K-1:0]       rsp_z;
    logic [IW-1:0]      rsp_id;
    logic               busy;

    typedef struct {
        logic [IW-1:0] id;
        logic [K-1:0]  z;
    } rsp_t;

    typedef struct {
        logic [MW-1:0]   x;
        logic [K*RN-1:0] rnd;
    } iss_t;

    rsp_t rsp_q[$];
    iss_t iss_q[$];
    int   rsp_cyc_q[$];
    rsp_t rsp_e;
    iss_t iss_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int grant_cnt = 0;
    int last_grant_cyc = 0;
    int rnd_hs = 0;
    int rsp_cnt = 0;
    int rnd_mode = 0;

    fullxor_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_word  (rnd_word),
        .xu_dvld   (xu_dvld),
        .xu_ena    (xu_ena),
        .xu_rnd    (xu_rnd),
        .xu_x      (xu_x),
        .xu_z      (xu_z),
        .xu_ovld   (xu_ovld),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [K-1:0] xor5(input logic [MW-1:0] x);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r = r ^ x[i*K +: K];
        return r;
    endfunction

    function automatic logic [K*RN-1:0] pack_rnd(input logic [K-1:0] w);
        logic [K*RN-1:0] p;
        for (int i = 0; i < RN; i++) p[i*K +: K] = w + K'(i);
        return p;
    endfunction

    function automatic logic [MW-1:0] rand_shares();
        logic [MW-1:0] s;
        for (int i = 0; i < 5; i++) s[i*K +: K] = $urandom;
        return s;
    endfunction

    // Behavioural xu: result one cycle after a data-valid while enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            xu_ovld <= 1'b0;
            xu_z    <= '0;
        end else begin
            xu_ovld <= xu_dvld & xu_ena;
            xu_z    <= xor5(xu_x);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input int r, input logic [MW-1:0] x, input logic [K-1:0] z,
                             input logic [K-1:0] w);
        rsp_t re;
        iss_t ie;
        re.id  = IW'(r);
        re.z   = z;
        ie.x   = x;
        ie.rnd = pack_rnd(w);
        rsp_q.push_back(re);
        iss_q.push_back(ie);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int i;
        i = 0;
        while (rsp_cnt < target && i < budget) begin
            step();
            i++;
        end
        chk("rsp_count", rsp_cnt, target);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_rnd_ready"}, rnd_ready, 0);
        chk({pfx, "_xu_dvld"}, xu_dvld, 0);
        chk({pfx, "_xu_ena"}, xu_ena, 0);
        chk({pfx, "_xu_x"}, xu_x, 0);
        chk({pfx, "_xu_rnd"}, xu_rnd, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_z"}, rsp_z, 0);
        chk({pfx, "_rsp_id"}, rsp_id, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Random source: a counting word that advances on each handshake.
    initial begin
        logic hs;
        int   ph;
        rnd_valid = 1'b0;
        rnd_word  = 32'd1;
        ph        = 0;
        forever begin
            @(negedge clk);
            hs = rnd_valid && rnd_ready && !rst;
            @(posedge clk);
            #1;
            if (hs) rnd_word = rnd_word + 32'd1;
            rnd_valid = (rnd_mode == 0) ? 1'b1 : ((ph % 3) == 0);
            ph++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!xu_dvld) begin
                chk("xu_x_idle", xu_x, 0);
                chk("xu_rnd_idle", xu_rnd, 0);
            end else if (iss_q.size() == 0) begin
                chk("issue_unexpected", 1, 0);
            end else begin
                iss_e = iss_q.pop_front();
                chk("issue_x", xu_x, iss_e.x);
                chk("issue_rnd", xu_rnd, iss_e.rnd);
                chk("issue_ena", xu_ena, 1);
            end
            if (req_ready != '0) begin
                grant_cnt++;
                last_grant_cyc = cyc;
                chk("ready_onehot", $onehot(req_ready), 1);
                chk("ready_has_valid", |(req_ready & req_valid), 1);
            end
            if (rnd_valid && rnd_ready) rnd_hs++;
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    rsp_e = rsp_q.pop_front();
                    chk("rsp_id", rsp_id, rsp_e.id);
                    chk("rsp_z", rsp_z, rsp_e.z);
                end
                rsp_cyc_q.push_back(cyc);
                rsp_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] s;
        logic [MW-1:0] sh[NREQ];
        logic [K-1:0]  w;
        int            g0;
        int            h0;
        int            base;
        int            i;
        int            n;

        req_valid = '0;
        req_x     = '0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        step();
        rst = 1'b0;

        // Single op with known shares; requester holds valid until its response.
        s = {32'h0000000F, 32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
        expect_op(0, s, 32'hFFFFFFF0, 32'd1);
        req_x[0 +: MW] = s;
        req_valid      = 4'b0001;
        g0             = grant_cnt;
        wait_rsp(1, 60);
        req_valid = '0;
        chk("single_latency", rsp_cyc_q[$] - last_grant_cyc, 8);
        chk("single_ready_pulses", grant_cnt - g0, 1);

        // Back-to-back op; requester drops valid right after the grant.
        s = rand_shares();
        req_x[2*MW +: MW] = s;
        expect_op(2, s, xor5(s), 32'd6);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        wait_rsp(2, 60);

        // Round robin over all four requesters from ptr=0.
        do_reset();
        w = rnd_word;
        for (int r = 0; r < NREQ; r++) begin
            sh[r] = rand_shares();
            req_x[r*MW +: MW] = sh[r];
        end
        for (int k = 0; k < 5; k++) expect_op(k % NREQ, sh[k % NREQ], xor5(sh[k % NREQ]), w + K'(5 * k));
        base      = rsp_cnt;
        g0        = grant_cnt;
        req_valid = 4'hF;
        i = 0;
        while (grant_cnt < g0 + 5 && i < 80) begin
            step();
            i++;
        end
        req_valid = '0;
        chk("rr_grants", grant_cnt - g0, 5);
        wait_rsp(base + 5, 80);
        n = rsp_cyc_q.size();
        for (int k = 1; k < 5; k++) chk("rr_gap", rsp_cyc_q[n-5+k] - rsp_cyc_q[n-6+k], 9);

        // Randomness arriving one cycle in three.
        rnd_mode = 1;
        h0   = rnd_hs;
        base = rsp_cnt;
        s    = rand_shares();
        req_x[1*MW +: MW] = s;
        expect_op(1, s, xor5(s), rnd_word);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        wait_rsp(base + 1, 150);
        chk("stall_rnd_handshakes", rnd_hs - h0, 5);
        rnd_mode = 0;

        // Response backpressure with another requester waiting.
        rsp_ready = 1'b0;
        base = rsp_cnt;
        g0   = grant_cnt;
        w    = rnd_word;
        sh[3] = rand_shares();
        sh[0] = rand_shares();
        req_x[3*MW +: MW] = sh[3];
        req_x[0 +: MW]    = sh[0];
        expect_op(3, sh[3], xor5(sh[3]), w);
        expect_op(0, sh[0], xor5(sh[0]), w + 32'd5);
        req_valid = 4'b1001;
        i = 0;
        while (!rsp_valid && i < 40) begin
            step();
            i++;
        end
        chk("bp_reach_resp", rsp_valid, 1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 3);
            chk("bp_z", rsp_z, xor5(sh[3]));
            chk("bp_busy", busy, 1);
            chk("bp_no_grant", req_ready, 0);
        end
        chk("bp_grants_held", grant_cnt - g0, 1);
        step();
        rsp_ready = 1'b1;
        i = 0;
        while (grant_cnt < g0 + 2 && i < 20) begin
            step();
            i++;
        end
        req_valid = '0;
        chk("bp_second_grant", grant_cnt - g0, 2);
        wait_rsp(base + 2, 40);

        // Reset while waiting on xu: op is dropped without a response.
        base = rsp_cnt;
        s    = rand_shares();
        req_x[1*MW +: MW] = s;
        expect_op(1, s, xor5(s), rnd_word);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        i = 0;
        while (!(xu_ena && !xu_dvld) && i < 40) begin
            step();
            i++;
        end
        chk("mid_reach_wait", xu_ena & ~xu_dvld, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        step();
        rst = 1'b0;
        rsp_q.delete();
        chk("mid_issue_drained", iss_q.size(), 0);
        repeat (12) step();
        chk("mid_no_rsp", rsp_cnt, base);

        s = rand_shares();
        req_x[2*MW +: MW] = s;
        expect_op(2, s, xor5(s), rnd_word);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        wait_rsp(base + 1, 60);

        chk("sb_rsp_empty", rsp_q.size(), 0);
        chk("sb_issue_empty", iss_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
